dmem_mmio_responder: RTL and testbench
======================================

DMEM_MMIO_RESPONDER -- requirements
Module: dmem_mmio_responder

Interface
REQ-001 SHALL have parameter: DEPTH_WORDS, 1024, number of 32-bit RAM words; addresses 0x000..DEPTH_WORDS-1 map to RAM.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req  input  1  CPU data-port request strobe.
REQ-005 SHALL have port: wr_en  input  1  1=write, 0=read; sampled with req.
REQ-006 SHALL have port: addr  input  11  word address; sampled with req.
REQ-007 SHALL have port: wdata  input  32  write data; sampled with req.
REQ-008 SHALL have port: rdata  output  32  read data; valid while ack=1.
REQ-009 SHALL have port: ack  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: err  output  1  one-cycle pulse, coincident with ack, for unmapped access.
REQ-011 SHALL have port: sw_in  input  10  asynchronous board switches.
REQ-012 SHALL have port: led_out  output  10  LED register.
REQ-013 SHALL have port: hex_out  output  32  seven-segment pattern register.

Function
REQ-014 SHALL implement FSM states IDLE, RD_WAIT, RESP.
REQ-015 SHALL accept a request only in IDLE with req=1, capturing wr_en, addr and wdata on that edge.
REQ-016 SHALL ignore req in RD_WAIT and RESP; the CPU holds req until ack.
REQ-017 SHALL perform a RAM write on the accept edge, then go to RESP; ack follows 1 cycle after accept.
REQ-018 SHALL perform a RAM read with synchronous RAM: IDLE->RD_WAIT->RESP; ack follows 2 cycles after accept.
REQ-019 SHALL complete MMIO accesses (addr 0x400..0x403) and unmapped accesses IDLE->RESP; ack follows 1 cycle after accept.
REQ-020 SHALL map MMIO as: 0x400 LED, RW, bits[9:0], upper bits read 0; 0x401 HEX, RW, 32 bits; 0x402 switches, RO; 0x403 cycle counter, RO.
REQ-021 SHALL silently discard writes to RO addresses, with ack and no err.
REQ-022 SHALL treat RAM addresses >= DEPTH_WORDS below 0x400, and 0x404..0x7FF, as unmapped: reads return 0xDEADBEEF, writes are discarded, err=1.
REQ-023 SHALL pass sw_in through a 2-flop synchronizer before it is readable.
REQ-024 SHALL hold rdata at its last value after ack falls; rdata is 0 after a write ack.
REQ-025 SHALL return RESP->IDLE unconditionally; req still high in IDLE starts a new access. Maximum throughput is one access per 2 cycles (MMIO/write) or 3 cycles (RAM read).

Reset
REQ-026 SHALL, on rst_n=0, immediately force: state=IDLE, ack=0, err=0, rdata=0, led_out=0, hex_out=0x7F7F7F7F (all segments off), synchronizer=0, counter=0.
REQ-027 SHALL abandon an in-flight access on reset with no ack; RAM contents are not cleared, and a write already performed on its accept edge persists.

Configuration
REQ-028 SHALL, with DMEM_CYCLE_COUNTER_EN defined, include a 32-bit free-running counter that increments every cycle, wraps 0xFFFFFFFF->0, and is readable at 0x403.
REQ-029 SHALL, without DMEM_CYCLE_COUNTER_EN, contain no counter; 0x403 reads 0 with no err.

Structure
REQ-030 SHALL place the FSM state enum, MMIO address constants, DEADBEEF fill value and HEX reset pattern in a shared package, dmem_pkg.
REQ-031 SHALL instantiate one sub-module, dmem_ram: a single-port synchronous DEPTH_WORDS x 32 RAM.

Verification
REQ-032 SHALL cover: write 0x12345678 @0x010, then read @0x010 -> ack 1 cycle after write accept; read ack 2 cycles after accept with rdata=0x12345678.
REQ-033 SHALL cover: write 0x3FF @0x400, read @0x400 -> led_out=0x3FF, rdata=0x000003FF; write 0xFFFFFFFF @0x400 -> rdata=0x000003FF.
REQ-034 SHALL cover: sw_in=0x2A5 held, read @0x402 -> rdata=0x2A5; write @0x402 -> ack, no err, value unchanged.
REQ-035 SHALL cover: read @0x500 -> rdata=0xDEADBEEF, ack=err=1 for exactly one cycle; write @0x500 -> err=1, no state change.
REQ-036 SHALL cover: rst_n low during RD_WAIT -> no ack, led_out=0, hex_out=0x7F7F7F7F; a subsequent read of a previously written RAM word still returns its data.
REQ-037 SHALL cover: with DMEM_CYCLE_COUNTER_EN defined, two reads of 0x403 accepted N cycles apart differ by N; without it, both return 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory / MMIO responder.
//   - dmem_state_e : responder FSM states (IDLE, RD_WAIT, RESP)
//   - MMIO_*_ADDR  : word addresses of the four memory-mapped registers
//   - FILL_VALUE   : read data returned for unmapped addresses
//   - HEX_RESET    : seven-segment reset pattern (all segments off)
//   - is_mmio()    : decode helper for the 0x400..0x403 window
// ----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } dmem_state_e;

    localparam logic [10:0] MMIO_LED_ADDR = 11'h400;
    localparam logic [10:0] MMIO_HEX_ADDR = 11'h401;
    localparam logic [10:0] MMIO_SW_ADDR  = 11'h402;
    localparam logic [10:0] MMIO_CNT_ADDR = 11'h403;

    localparam logic [31:0] FILL_VALUE = 32'hDEAD_BEEF;
    localparam logic [31:0] HEX_RESET  = 32'h7F7F_7F7F;

    // The MMIO window is the four words sharing the LED address' upper bits.
    function automatic logic is_mmio(input logic [10:0] a);
        return (a[10:2] == MMIO_LED_ADDR[10:2]);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// ----------------------------------------------------------------------------
// dmem_ram
// Single-port synchronous RAM, DEPTH_WORDS x 32. Read data appears on rdata_o
// the cycle after an enabled read and holds until the next enabled read.
// Contents are not reset.
//   clk      in   clock
//   en_i     in   access enable
//   we_i     in   1=write, 0=read (qualified by en_i)
//   addr_i   in   word address
//   wdata_i  in   write data
//   rdata_o  out  registered read data
// ----------------------------------------------------------------------------
module dmem_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Storage array and registered read port.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_mmio_responder.sv
// ----------------------------------------------------------------------------
// dmem_mmio_responder
// CPU data-port responder: RAM at 0x000..DEPTH_WORDS-1, MMIO at 0x400..0x403
// (LED, HEX, switches, cycle counter), everything else unmapped (err pulse,
// reads return 0xDEADBEEF). Writes/MMIO/unmapped ack one cycle after accept,
// RAM reads two cycles after accept.
// Optional feature macro: DMEM_CYCLE_COUNTER_EN adds a 32-bit free-running
// cycle counter readable at 0x403 (reads 0 when the macro is undefined).
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   req      in   request strobe, held by the CPU until ack
//   wr_en    in   1=write, 0=read
//   addr     in   11-bit word address
//   wdata    in   write data
//   rdata    out  read data, valid with ack, held afterwards (0 after write)
//   ack      out  one-cycle completion pulse
//   err      out  one-cycle unmapped-access pulse, coincident with ack
//   sw_in    in   asynchronous switches (2-flop synchronized)
//   led_out  out  LED register
//   hex_out  out  seven-segment register
// ----------------------------------------------------------------------------
module dmem_mmio_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        wr_en,
    input  logic [10:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    input  logic [9:0]  sw_in,
    output logic [9:0]  led_out,
    output logic [31:0] hex_out
);

    localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

    dmem_state_e state_q, state_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [9:0]  led_q, led_d;
    logic [31:0] hex_q, hex_d;
    logic [9:0]  sw_meta_q, sw_sync_q;
    logic [31:0] cnt_s;
    logic [31:0] mmio_rdata_s;
    logic [31:0] ram_rdata_s;
    logic        ram_en_s, ram_we_s;
    logic        is_ram_s, is_mmio_s;

    // RAM never overlaps the MMIO window even if DEPTH_WORDS exceeds 0x400.
    assign is_ram_s  = (addr[10] == 1'b0) && ({21'd0, addr} < DEPTH_U);
    assign is_mmio_s = is_mmio(addr);

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en_s),
        .we_i    (ram_we_s),
        .addr_i  (addr[AW-1:0]),
        .wdata_i (wdata),
        .rdata_o (ram_rdata_s)
    );

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] cnt_q;

    // Free-running cycle counter; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign cnt_s = cnt_q;
`else
    assign cnt_s = 32'd0;
`endif

    // Two-flop synchronizer for the asynchronous switch inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q <= 10'd0;
            sw_sync_q <= 10'd0;
        end else begin
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
        end
    end

    // Read mux for the MMIO window; anything else outside RAM is fill value.
    always_comb begin
        mmio_rdata_s = FILL_VALUE;
        case (addr)
            MMIO_LED_ADDR: mmio_rdata_s = {22'd0, led_q};
            MMIO_HEX_ADDR: mmio_rdata_s = hex_q;
            MMIO_SW_ADDR:  mmio_rdata_s = {22'd0, sw_sync_q};
            MMIO_CNT_ADDR: mmio_rdata_s = cnt_s;
            default:       mmio_rdata_s = FILL_VALUE;
        endcase
    end

    // FSM next-state, RAM control and response/register updates.
    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        led_d    = led_q;
        hex_d    = hex_q;
        ram_en_s = 1'b0;
        ram_we_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (wr_en) begin
                        // Every write side effect happens on the accept edge.
                        state_d = RESP;
                        ack_d   = 1'b1;
                        rdata_d = 32'd0;
                        if (is_ram_s) begin
                            ram_en_s = 1'b1;
                            ram_we_s = 1'b1;
                        end else if (addr == MMIO_LED_ADDR) begin
                            led_d = wdata[9:0];
                        end else if (addr == MMIO_HEX_ADDR) begin
                            hex_d = wdata;
                        end else if (is_mmio_s) begin
                            led_d = led_q;  // read-only register: discard
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (is_ram_s) begin
                        ram_en_s = 1'b1;
                        state_d  = RD_WAIT;
                    end else begin
                        state_d = RESP;
                        ack_d   = 1'b1;
                        rdata_d = mmio_rdata_s;
                        err_d   = !is_mmio_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                state_d = RESP;
                ack_d   = 1'b1;
                rdata_d = ram_rdata_s;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            led_q   <= 10'd0;
            hex_q   <= HEX_RESET;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            led_q   <= led_d;
            hex_q   <= hex_d;
        end
    end

    assign ack     = ack_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign led_out = led_q;
    assign hex_out = hex_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_mmio_responder
// Self-checking bench for dmem_mmio_responder: a directed vector table,
// hand-written reset/counter sequences, and randomized accesses checked
// against a behavioural memory-map model. Honors DMEM_CYCLE_COUNTER_EN.
// ----------------------------------------------------------------------------
module tb_dmem_mmio_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        wr_en = 1'b0;
    logic [10:0] addr = 11'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic [9:0]  sw_in = 10'd0;
    logic [9:0]  led_out;
    logic [31:0] hex_out;

    int     checks = 0;
    int     failures = 0;
    longint t_p1 = 0;   // time of first rising edge after reset release

    dmem_mmio_responder #(.DEPTH_WORDS(1024)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .wr_en   (wr_en),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .ack     (ack),
        .err     (err),
        .sw_in   (sw_in),
        .led_out (led_out),
        .hex_out (hex_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [10:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
        logic [9:0]  exp_led;
        logic [31:0] exp_hex;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge
    // with the DUT idle again. Latency = rising edges from accept until the
    // CPU would sample ack high.
    task automatic access(input bit wr, input logic [10:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output bit e, output int lat,
                          output longint tacc);
        bit seen;
        seen = 1'b0;
        rd   = 32'd0;
        e    = 1'b0;
        lat  = 0;
        req = 1'b1; wr_en = wr; addr = a; wdata = d;
        @(posedge clk);
        tacc = $time;
        for (int k = 1; k <= 4; k++) begin
            if (!seen) begin
                @(negedge clk);
                if (ack === 1'b1) begin
                    seen = 1'b1;
                    lat  = k;
                    rd   = rdata;
                    e    = err;
                end
            end
        end
        req = 1'b0;
        chk("ack_seen", {31'd0, seen}, 32'd1);
        @(negedge clk);
        chk("ack_pulse_low", {31'd0, ack}, 32'd0);
        chk("err_pulse_low", {31'd0, err}, 32'd0);
        chk("rdata_hold", rdata, rd);
    endtask

    function automatic logic [31:0] exp_cnt(input longint tacc);
`ifdef DMEM_CYCLE_COUNTER_EN
        return 32'((tacc - t_p1) / 10);
`else
        return 32'd0;
`endif
    endfunction

    task automatic release_reset();
        rst_n = 1'b1;
        t_p1  = $time + 5;
    endtask

    logic [31:0] rd, ra, rb;
    bit          e;
    int          lat;
    longint      tacc, ta, tb;
    logic [31:0] mdl_mem [int];
    logic [9:0]  mdl_led;
    logic [31:0] mdl_hex;
    logic [9:0]  mdl_sw;

    initial begin
        // Directed vectors (sw_in = 0x2A5 held throughout).
        vecs.push_back('{1'b1, 11'h010, 32'h12345678, 32'h0,        1'b0, 1, 10'h000, 32'h7F7F7F7F});
        vecs.push_back('{1'b0, 11'h010, 32'h0,        32'h12345678, 1'b0, 2, 10'h000, 32'h7F7F7F7F});
        vecs.push_back('{1'b1, 11'h400, 32'h000003FF, 32'h0,        1'b0, 1, 10'h3FF, 32'h7F7F7F7F});
        vecs.push_back('{1'b0, 11'h400, 32'h0,        32'h000003FF, 1'b0, 1, 10'h3FF, 32'h7F7F7F7F});
        vecs.push_back('{1'b1, 11'h400, 32'hFFFFFFFF, 32'h0,        1'b0, 1, 10'h3FF, 32'h7F7F7F7F});
        vecs.push_back('{1'b0, 11'h400, 32'h0,        32'h000003FF, 1'b0, 1, 10'h3FF, 32'h7F7F7F7F});
        vecs.push_back('{1'b1, 11'h401, 32'hA1B2C3D4, 32'h0,        1'b0, 1, 10'h3FF, 32'hA1B2C3D4});
        vecs.push_back('{1'b0, 11'h401, 32'h0,        32'hA1B2C3D4, 1'b0, 1, 10'h3FF, 32'hA1B2C3D4});
        vecs.push_back('{1'b0, 11'h402, 32'h0,        32'h000002A5, 1'b0, 1, 10'h3FF, 32'hA1B2C3D4});
        vecs.push_back('{1'b1, 11'h402, 32'h00000000, 32'h0,        1'b0, 1, 10'h3FF, 32'hA1B2C3D4});
        vecs.push_back('{1'b0, 11'h402, 32'h0,        32'h000002A5, 1'b0, 1, 10'h3FF, 32'hA1B2C3D4});
        vecs.push_back('{1'b0, 11'h500, 32'h0,        32'hDEADBEEF, 1'b1, 1, 10'h3FF, 32'hA1B2C3D4});
        vecs.push_back('{1'b1, 11'h500, 32'h11111111, 32'h0,        1'b1, 1, 10'h3FF, 32'hA1B2C3D4});
        vecs.push_back('{1'b0, 11'h500, 32'h0,        32'hDEADBEEF, 1'b1, 1, 10'h3FF, 32'hA1B2C3D4});
        vecs.push_back('{1'b1, 11'h3FF, 32'hCAFEF00D, 32'h0,        1'b0, 1, 10'h3FF, 32'hA1B2C3D4});
        vecs.push_back('{1'b0, 11'h3FF, 32'h0,        32'hCAFEF00D, 1'b0, 2, 10'h3FF, 32'hA1B2C3D4});
        vecs.push_back('{1'b0, 11'h7FF, 32'h0,        32'hDEADBEEF, 1'b1, 1, 10'h3FF, 32'hA1B2C3D4});
        vecs.push_back('{1'b1, 11'h404, 32'h22222222, 32'h0,        1'b1, 1, 10'h3FF, 32'hA1B2C3D4});
        vecs.push_back('{1'b0, 11'h404, 32'h0,        32'hDEADBEEF, 1'b1, 1, 10'h3FF, 32'hA1B2C3D4});
        vecs.push_back('{1'b0, 11'h010, 32'h0,        32'h12345678, 1'b0, 2, 10'h3FF, 32'hA1B2C3D4});

        // Reset values.
        sw_in = 10'h2A5;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_led", {22'd0, led_out}, 32'd0);
        chk("rst_hex", hex_out, 32'h7F7F7F7F);
        release_reset();

        foreach (vecs[i]) begin
            access(vecs[i].wr, vecs[i].a, vecs[i].d, rd, e, lat, tacc);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_led", i), {22'd0, led_out}, {22'd0, vecs[i].exp_led});
            chk($sformatf("vec%0d_hex", i), hex_out, vecs[i].exp_hex);
        end

        // Reset in RESP right after a RAM write: the write must persist.
        req = 1'b1; wr_en = 1'b1; addr = 11'h020; wdata = 32'h0BADF00D;
        @(posedge clk);
        #1 rst_n = 1'b0; req = 1'b0;
        #1 chk("rstw_ack", {31'd0, ack}, 32'd0);
        @(negedge clk);
        release_reset();

        // Reset during RD_WAIT: no ack, registers back to reset values.
        access(1'b1, 11'h400, 32'h00000155, rd, e, lat, tacc);
        access(1'b1, 11'h401, 32'h01020304, rd, e, lat, tacc);
        chk("pre_rst_led", {22'd0, led_out}, 32'h155);
        req = 1'b1; wr_en = 1'b0; addr = 11'h010;
        @(posedge clk);
        #2 rst_n = 1'b0; req = 1'b0;
        #1;
        chk("rstrd_ack", {31'd0, ack}, 32'd0);
        chk("rstrd_rdata", rdata, 32'd0);
        chk("rstrd_led", {22'd0, led_out}, 32'd0);
        chk("rstrd_hex", hex_out, 32'h7F7F7F7F);
        repeat (2) @(negedge clk);
        release_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_no_ack", {31'd0, ack}, 32'd0);
        end
        access(1'b0, 11'h010, 32'd0, rd, e, lat, tacc);
        chk("ram_keep_010", rd, 32'h12345678);
        access(1'b0, 11'h020, 32'd0, rd, e, lat, tacc);
        chk("ram_keep_020", rd, 32'h0BADF00D);
        chk("ram_keep_lat", 32'(lat), 32'd2);

        // Cycle counter: two reads accepted 2+5 cycles apart.
        access(1'b0, 11'h403, 32'd0, ra, e, lat, ta);
        chk("cnt_err_a", {31'd0, e}, 32'd0);
        repeat (5) @(negedge clk);
        access(1'b0, 11'h403, 32'd0, rb, e, lat, tb);
        chk("cnt_err_b", {31'd0, e}, 32'd0);
        chk("cnt_gap_time", 32'((tb - ta) / 10), 32'd7);
`ifdef DMEM_CYCLE_COUNTER_EN
        chk("cnt_diff", rb - ra, 32'd7);
`else
        chk("cnt_a_zero", ra, 32'd0);
        chk("cnt_b_zero", rb, 32'd0);
`endif
        chk("cnt_abs", ra, exp_cnt(ta));

        // Randomized accesses against the behavioural memory map.
        rst_n = 1'b0;
        @(negedge clk);
        release_reset();
        mdl_led = 10'd0;
        mdl_hex = 32'h7F7F7F7F;
        mdl_sw  = sw_in;
        for (int it = 0; it < 200; it++) begin
            int          sel;
            bit          wr, is_ram, is_unm;
            logic [10:0] a;
            logic [31:0] d, exp_rd;
            if ($urandom_range(0, 9) == 0) begin
                sw_in  = 10'($urandom_range(0, 1023));
                mdl_sw = sw_in;
                repeat (3) @(negedge clk);
            end
            sel = $urandom_range(0, 3);
            if (sel < 2)       a = 11'(11'h040 + $urandom_range(0, 15));
            else if (sel == 2) a = 11'(11'h400 + $urandom_range(0, 3));
            else               a = 11'($urandom_range(11'h404, 11'h7FF));
            is_ram = (a < 11'd1024);
            is_unm = (a > 11'h403);
            wr = 1'($urandom_range(0, 1));
            if (is_ram && !wr && !mdl_mem.exists(int'(a))) wr = 1'b1;
            d = $urandom;
            access(wr, a, d, rd, e, lat, tacc);
            exp_rd = 32'd0;
            if (wr) begin
                if (is_ram)            mdl_mem[int'(a)] = d;
                else if (a == 11'h400) mdl_led = d[9:0];
                else if (a == 11'h401) mdl_hex = d;
            end else if (is_ram) exp_rd = mdl_mem[int'(a)];
            else if (a == 11'h400) exp_rd = {22'd0, mdl_led};
            else if (a == 11'h401) exp_rd = mdl_hex;
            else if (a == 11'h402) exp_rd = {22'd0, mdl_sw};
            else if (a == 11'h403) exp_rd = exp_cnt(tacc);
            else                   exp_rd = 32'hDEADBEEF;
            chk($sformatf("rnd%0d_rdata@%03h", it, a), rd, exp_rd);
            chk($sformatf("rnd%0d_err@%03h", it, a), {31'd0, e}, {31'd0, is_unm});
            chk($sformatf("rnd%0d_lat@%03h", it, a), 32'(lat), (is_ram && !wr) ? 32'd2 : 32'd1);
            chk($sformatf("rnd%0d_led", it), {22'd0, led_out}, {22'd0, mdl_led});
            chk($sformatf("rnd%0d_hex", it), hex_out, mdl_hex);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
